// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO, baud select and stop/parity options.
// Optional parity stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV0       = 868,
  parameter int DIV1       = 434,
  parameter int DIV2       = 217,
  parameter int DIV3       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    sel,
  input  logic                          stop2,
  input  logic                          par_odd,
  input  logic                          tx_valid,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          out_clk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         div_q, div_d, div_max;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [1:0]          sel_q;
  logic                stop2_q;
  logic                tx_q, tx_d;
  logic                push, pop, full, tick;

`ifdef UART_TX_PARITY_EN
  logic                par_q;
`else
  logic                unused_par;
  assign unused_par = par_odd;
`endif

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign fifo_cnt = cnt_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != S_IDLE) || (cnt_q != '0);
  assign tick     = (state_q != S_IDLE) && (div_q == div_max);
  assign out_clk  = tick;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);

  // Divisor comes from the per-frame latched select, not the live input.
  always_comb begin
    unique case (sel_q)
      2'b00: div_max = 16'(DIV0 - 1);
      2'b01: div_max = 16'(DIV1 - 1);
      2'b10: div_max = 16'(DIV2 - 1);
      2'b11: div_max = 16'(DIV3 - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + 16'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
          div_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (stop2_q && !bit_q[0]) begin
            bit_d = 1'b1;
          end else begin
            bit_d = '0;
            // Chain straight into the next frame when work is queued.
            if (cnt_q != '0) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d = mem_q[rd_q];
    end
  end

  // Line level follows the current state, one edge behind the transition.
  always_comb begin
    unique case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sel_q   <= '0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q    <= rd_q + 1'b1;
        sel_q   <= sel;
        stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
        par_q   <= (^mem_q[rd_q]) ^ par_odd;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for uart_tx_fifo_param: stimulus queues expected frames,
// a line monitor decodes tx and compares. Honors UART_TX_PARITY_EN.
module tb_uart_tx_fifo_param;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sel = 2'b11;
  logic       stop2 = 1'b0;
  logic       par_odd = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, tx, tx_busy, out_clk;
  logic [2:0] fifo_cnt;

  uart_tx_fifo_param dut (
    .clk(clk), .reset(reset), .sel(sel), .stop2(stop2),
    .par_odd(par_odd), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy),
    .out_clk(out_clk), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         stop2;
    bit         par;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0, oclk_cnt = 0, low_cnt = 0;
  int b0, o0, l0;

  always @(negedge clk) begin
    busy_cnt <= busy_cnt + int'(tx_busy);
    oclk_cnt <= oclk_cnt + int'(out_clk);
    low_cnt  <= low_cnt + int'(tx === 1'b0);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    @(posedge clk);
    b0 = busy_cnt; o0 = oclk_cnt; l0 = low_cnt;
    @(negedge clk);
  endtask

  task automatic deltas(input string name, input int eb, input int eo);
    @(posedge clk);
    check({name, "_busy_cycles"}, busy_cnt - b0, eb);
    check({name, "_out_clk"}, oclk_cnt - o0, eo);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] ed,
                      input int div, input bit s2, input bit par,
                      input bit want);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("push_ready_timeout", tx_ready, 1);
    if (want) exp_q.push_back('{ed, div, s2, par});
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (tx_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", tx_busy, 0);
  endtask

  initial begin : mon
    exp_t e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) begin
          while (tx !== 1'b1) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          repeat (e.div / 2) @(negedge clk);
          check("start_bit", tx, 0);
          for (int i = 0; i < 8; i++) begin
            repeat (e.div) @(negedge clk);
            got[i] = tx;
          end
`ifdef UART_TX_PARITY_EN
          repeat (e.div) @(negedge clk);
          check("parity_bit", tx, e.par);
`endif
          repeat (e.div) @(negedge clk);
          check("stop_bit", tx, 1);
          if (e.stop2) begin
            repeat (e.div) @(negedge clk);
            check("stop_bit2", tx, 1);
          end
          check("frame_data", got, e.data);
        end
      end
    end
  end

  initial begin
    // 1: reset held for 10 cycles
    snap();
    repeat (10) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_cnt", fifo_cnt, 0);
    deltas("rst", 0, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 2: single A5 frame at 16 clk/bit, then a two-stop-bit frame
    snap();
    push(8'hA5, 8'hA5, 16, 0, 0, 1);
    wait_idle(1000);
    @(posedge clk);
    check("a5_low_cycles", low_cnt - l0, 80 + P * 16);
    @(negedge clk);
    deltas("a5", 1 + (10 + P) * 16, 10 + P);
    stop2 = 1'b1;
    snap();
    push(8'h5A, 8'h5A, 16, 1, 0, 1);
    wait_idle(1000);
    deltas("stop2", 1 + (11 + P) * 16, 11 + P);
    stop2 = 1'b0;

`ifdef UART_TX_PARITY_EN
    // 3: odd parity sense on A5
    par_odd = 1'b1;
    snap();
    push(8'hA5, 8'hA5, 16, 0, 1, 1);
    wait_idle(1000);
    deltas("odd_par", 1 + 11 * 16, 11);
    par_odd = 1'b0;
`endif

    // 4: five words into a four-deep FIFO
    snap();
    push(8'h01, 8'h01, 16, 0, 1, 1);
    push(8'h80, 8'h80, 16, 0, 1, 1);
    push(8'h3C, 8'h3C, 16, 0, 0, 1);
    push(8'hFF, 8'hFF, 16, 0, 0, 1);
    push(8'h00, 8'h00, 16, 0, 0, 1);
    check("full_cnt", fifo_cnt, 4);
    check("full_ready", tx_ready, 0);
    for (int n = 0; n < 400 && !tx_ready; n++) @(negedge clk);
    check("reready", tx_ready, 1);
    check("reready_cnt", fifo_cnt, 3);
    wait_idle(2000);
    deltas("burst", 1 + 5 * (10 + P) * 16, 5 * (10 + P));

    // 5: select changes mid-frame only affect the next frame
    snap();
    push(8'hA5, 8'hA5, 16, 0, 0, 1);
    repeat (40) @(negedge clk);
    sel = 2'b00;
    push(8'h3C, 8'h3C, 868, 0, 0, 1);
    wait_idle(12000);
    deltas("sel_switch", 1 + (10 + P) * 16 + (10 + P) * 868, 2 * (10 + P));
    sel = 2'b11;

    // 6: reset during data bit 3 with two words queued
    push(8'hA5, 8'hFD, 16, 0, 1, 1);
    push(8'h11, 8'h00, 16, 0, 0, 0);
    push(8'h22, 8'h00, 16, 0, 0, 0);
    check("queued_cnt", fifo_cnt, 2);
    repeat (64) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_cnt", fifo_cnt, 0);
    check("abort_busy", tx_busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    snap();
    repeat (300) @(negedge clk);
    @(posedge clk);
    check("post_abort_low", low_cnt - l0, 0);
    @(negedge clk);
    check("post_abort_busy", tx_busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
